// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO read-side engine: FSM state encoding and FIFO timing.
// Imported by fifo_reader and its circular output buffer.
package pipearch_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fifo_reader_state_t;

  // Cycles from re to rvalid/rdata on the attached FIFO.
  localparam int FIFO_READ_LATENCY = 1;

  function automatic int unsigned buf_depth(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO/BRAM access bundle: fifo_sink is the reader side, fifo_source the FIFO side.
interface fifobram_interface #(
  parameter int WIDTH = 8
);
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic             empty;
  logic             full;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport fifo_sink (
    output re,
    input  empty,
    input  rvalid,
    input  rdata
  );

  modport fifo_source (
    input  we,
    input  wdata,
    input  re,
    output empty,
    output full,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fifo_reader_buf.sv
// Small circular buffer holding {last, data} entries between the FIFO read port and
// the output stream; wrap-around pointers plus an explicit occupancy count.
module fifo_reader_buf #(
  parameter int WIDTH    = 8,
  parameter int LOG2_BUF = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              push_last,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic              out_last,
  output logic [WIDTH-1:0]  out_data,
  output logic [LOG2_BUF:0] count
);
  import pipearch_fifo_pkg::*;

  localparam int                DEPTH   = buf_depth(LOG2_BUF);
  localparam logic [LOG2_BUF:0] DEPTH_C = (LOG2_BUF + 1)'(DEPTH);
  localparam logic [LOG2_BUF:0] ONE_C   = (LOG2_BUF + 1)'(1);
  localparam logic [LOG2_BUF-1:0] PTR_ONE = LOG2_BUF'(1);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [LOG2_BUF-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_BUF-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_BUF:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{last: push_last, data: push_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_last  = mem_q[rd_ptr_q].last;
  assign out_data  = mem_q[rd_ptr_q].data;
  assign count     = count_q;

  // The reader's credit rule keeps the buffer from ever filling past its depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && count_q == DEPTH_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && count_q == '0));

endmodule

// File: rtl/fifo_reader.sv
// Drains a commanded number of words from a FIFO and presents them as a valid/ready
// stream. Optional FIFO_READER_STATS_EN adds stall_cycles/starve_cycles counters.
module fifo_reader
  import pipearch_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LOG2_BUF  = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  output logic                 busy,
  output logic                 done,
  fifobram_interface.fifo_sink access,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] starve_cycles
`endif
);

  localparam int                  DEPTH   = buf_depth(LOG2_BUF);
  localparam logic [LOG2_BUF+1:0] DEPTH_W = (LOG2_BUF + 2)'(DEPTH);
  localparam logic [LOG2_BUF:0]   BUF_ONE = (LOG2_BUF + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  fifo_reader_state_t   state_q, state_d;
  logic [CNT_WIDTH-1:0] issue_left_q, issue_left_d;
  logic [CNT_WIDTH-1:0] recv_left_q, recv_left_d;
  logic                 inflight_q, inflight_d;

  logic                 re;
  logic                 refund;
  logic                 push;
  logic                 push_last;
  logic                 pop;
  logic                 buf_empty_next;
  logic [LOG2_BUF:0]    buf_count;
  logic [LOG2_BUF+1:0]  credit;

  // A slot is reserved for the outstanding read so the returning word always fits.
  assign credit    = {1'b0, buf_count} + {{(LOG2_BUF + 1){1'b0}}, inflight_q};
  assign re        = (state_q == ISSUE) && !access.empty && (issue_left_q != '0)
                     && (credit < DEPTH_W);
  assign refund    = inflight_q && !access.rvalid;
  assign push      = inflight_q && access.rvalid;
  assign push_last = (recv_left_q == CNT_ONE);
  assign pop       = out_valid && out_ready;
  assign buf_empty_next = ((buf_count == '0) && !push)
                       || ((buf_count == BUF_ONE) && pop && !push);

  assign access.re = re;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d      = state_q;
    issue_left_d = issue_left_q;
    recv_left_d  = recv_left_q;
    inflight_d   = re;

    if (re && !refund) begin
      issue_left_d = issue_left_q - CNT_ONE;
    end else if (!re && refund) begin
      issue_left_d = issue_left_q + CNT_ONE;
    end
    if (push) begin
      recv_left_d = recv_left_q - CNT_ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = DONE;
          end else begin
            issue_left_d = num_words;
            recv_left_d  = num_words;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_left_d == '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // A missed rvalid hands the word back to ISSUE for another attempt.
        if (issue_left_d != '0) begin
          state_d = ISSUE;
        end else if ((recv_left_d == '0) && buf_empty_next) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      issue_left_q <= '0;
      recv_left_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      recv_left_q  <= recv_left_d;
      inflight_q   <= inflight_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH    (WIDTH),
    .LOG2_BUF (LOG2_BUF)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_last (push_last),
    .push_data (access.rdata),
    .pop       (pop),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .count     (buf_count)
  );

`ifdef FIFO_READER_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] starve_q, starve_d;

  // Counters restart on each accepted command and saturate instead of wrapping.
  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if ((state_q == IDLE) && start) begin
      stall_d  = '0;
      starve_d = '0;
    end else begin
      if (busy && out_valid && !out_ready && (stall_q != '1)) begin
        stall_d = stall_q + CNT_ONE;
      end
      if ((state_q == ISSUE) && (issue_left_q != '0) && access.empty
          && (starve_q != '1)) begin
        starve_d = starve_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif

endmodule
